// File: rtl/ax_kogge_stone_pipe.sv
// Three-stage approximate Kogge-Stone adder with a per-beat exact/approximate switch.
// The exact sum is computed in parallel for every beat and feeds saturating error counters.
module ax_kogge_stone_pipe #(
  parameter int WIDTH = 16,
  parameter int K     = 8,
  parameter int ERR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH:1]     A,
  input  logic [WIDTH:1]     B,
  input  logic               Carry_in,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH+1:1]   Sum,
  output logic [WIDTH:0]     Carry_Out,
  input  logic               err_clr,
  output logic [ERR_W-1:0]   err_count,
  output logic [ERR_W-1:0]   err_dist
);

  localparam int DW = ((ERR_W > WIDTH + 1) ? ERR_W : WIDTH + 1) + 1;

  // Position 0 of every prefix vector carries the seed (g = carry-in, p = 0).
  function automatic logic [WIDTH:0] ks_prefix(input logic [WIDTH:0] g_in,
                                               input logic [WIDTH:0] p_in);
    logic [WIDTH:0] g, p, g_nx, p_nx;
    g = g_in;
    p = p_in;
    for (int d = 1; d <= WIDTH; d = d * 2) begin
      g_nx = g;
      p_nx = p;
      for (int j = d; j <= WIDTH; j++) begin
        g_nx[j] = g[j] | (p[j] & g[j-d]);
        p_nx[j] = p[j] & p[j-d];
      end
      g = g_nx;
      p = p_nx;
    end
    return g;
  endfunction

  logic adv;
  assign in_ready = out_ready | ~out_valid;
  assign adv      = in_ready;

  logic           s1_valid, s1_apx;
  logic [WIDTH:0] s1_g;
  logic [WIDTH:1] s1_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_apx   <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_apx   <= approx_en;
      s1_g     <= {A & B, Carry_in};
      s1_p     <= A ^ B;
    end
  end

  logic [WIDTH:0] p_full, g_ap, p_ap, c_ex_nx, c_ap_nx;

  // Approximate path: bits below K are killed, bit K seeds the upper prefix with G[K]
  // (or Carry_in when K=0), and the low carries are just the local generates.
  always_comb begin
    p_full = {s1_p, 1'b0};
    g_ap   = '0;
    p_ap   = '0;
    for (int j = 0; j <= WIDTH; j++) begin
      if (j >= K) g_ap[j] = s1_g[j];
      if (j > K)  p_ap[j] = p_full[j];
    end
    c_ex_nx = ks_prefix(s1_g, p_full);
    c_ap_nx = ks_prefix(g_ap, p_ap);
    for (int j = 0; j <= K; j++) c_ap_nx[j] = s1_g[j];
  end

  logic           s2_valid, s2_apx;
  logic [WIDTH:1] s2_p;
  logic [WIDTH:0] s2_c_ex, s2_c_ap;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_apx   <= 1'b0;
      s2_p     <= '0;
      s2_c_ex  <= '0;
      s2_c_ap  <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_apx   <= s1_apx;
      s2_p     <= s1_p;
      s2_c_ex  <= c_ex_nx;
      s2_c_ap  <= c_ap_nx;
    end
  end

  logic [WIDTH-1:0] c_sum;
  logic [WIDTH+1:1] sum_ex_nx, sum_ap_nx;
  logic [WIDTH:0]   dist_nx;

  // Carry_in is reported on Carry_Out[0] in approximate mode but only enters the sum when K=0.
  always_comb begin
    c_sum = s2_c_ap[WIDTH-1:0];
    if (K > 0) c_sum[0] = 1'b0;
    sum_ex_nx = {s2_c_ex[WIDTH], s2_p ^ s2_c_ex[WIDTH-1:0]};
    sum_ap_nx = {s2_c_ap[WIDTH], s2_p ^ c_sum};
    dist_nx   = sum_ex_nx - sum_ap_nx;
  end

  logic           s3_apx, s3_diff;
  logic [WIDTH:0] s3_dist;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Sum       <= '0;
      Carry_Out <= '0;
      s3_apx    <= 1'b0;
      s3_diff   <= 1'b0;
      s3_dist   <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      Sum       <= s2_apx ? sum_ap_nx : sum_ex_nx;
      Carry_Out <= s2_apx ? s2_c_ap : s2_c_ex;
      s3_apx    <= s2_apx;
      s3_diff   <= (sum_ex_nx != sum_ap_nx);
      s3_dist   <= dist_nx;
    end
  end

  logic          hs;
  logic [DW-1:0] dist_acc;

  assign hs = out_valid & out_ready;

  always_comb begin
    dist_acc = DW'(err_dist) + DW'(s3_dist);
  end

  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_count <= '0;
      err_dist  <= '0;
    end else if (hs && s3_apx) begin
      if (s3_diff && (err_count != '1)) err_count <= err_count + ERR_W'(1);
      err_dist <= (|dist_acc[DW-1:ERR_W]) ? '1 : dist_acc[ERR_W-1:0];
    end
  end

endmodule

// File: tb/tb_ax_kogge_stone_pipe.sv
// Directed and swept checks for ax_kogge_stone_pipe at (16,8,32), (32,12,4) and (16,0,32).
module tb_ax_kogge_stone_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic        v0, ir0, ov0, or0, cin0, x0, clr0;
  logic [16:1] a0, b0;
  logic [17:1] s0;
  logic [16:0] co0;
  logic [31:0] ec0, ed0;

  logic        v1, ir1, ov1, cin1, x1;
  logic [32:1] a1, b1;
  logic [33:1] s1;
  logic [32:0] co1;
  logic [3:0]  ec1, ed1;

  logic        v2, ir2, ov2, cin2, x2;
  logic [16:1] a2, b2;
  logic [17:1] s2;
  logic [16:0] co2;
  logic [31:0] ec2, ed2;

  ax_kogge_stone_pipe #(.WIDTH(16), .K(8), .ERR_W(32)) u0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(ir0), .A(a0), .B(b0),
    .Carry_in(cin0), .approx_en(x0), .out_valid(ov0), .out_ready(or0),
    .Sum(s0), .Carry_Out(co0), .err_clr(clr0), .err_count(ec0), .err_dist(ed0));

  ax_kogge_stone_pipe #(.WIDTH(32), .K(12), .ERR_W(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .A(a1), .B(b1),
    .Carry_in(cin1), .approx_en(x1), .out_valid(ov1), .out_ready(1'b1),
    .Sum(s1), .Carry_Out(co1), .err_clr(1'b0), .err_count(ec1), .err_dist(ed1));

  ax_kogge_stone_pipe #(.WIDTH(16), .K(0), .ERR_W(32)) u2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2), .A(a2), .B(b2),
    .Carry_in(cin2), .approx_en(x2), .out_valid(ov2), .out_ready(1'b1),
    .Sum(s2), .Carry_Out(co2), .err_clr(1'b0), .err_count(ec2), .err_dist(ed2));

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bit-serial reference of both modes; bit 0 of the vectors maps to port index 1.
  function automatic void ref_add(input int w, input int k, input logic [63:0] a,
                                  input logic [63:0] b, input logic cin, input logic apx,
                                  output logic [64:0] sum, output logic [64:0] co);
    logic ai, bi, gp;
    sum = '0;
    co  = '0;
    co[0] = cin;
    gp = 1'b0;
    for (int i = 1; i <= w; i++) begin
      ai = a[i-1];
      bi = b[i-1];
      if (apx && i <= k) begin
        sum[i-1] = ai ^ bi ^ gp;
        co[i]    = ai & bi;
      end else begin
        sum[i-1] = ai ^ bi ^ co[i-1];
        co[i]    = (ai & bi) | ((ai ^ bi) & co[i-1]);
      end
      gp = ai & bi;
    end
    sum[w] = co[w];
  endfunction

  task automatic beat0(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic apx, output int lat);
    @(negedge clk);
    v0 = 1'b1; a0 = a; b0 = b; cin0 = cin; x0 = apx;
    @(negedge clk);
    v0 = 1'b0;
    lat = 1;
    while (!ov0 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    if (!ov0) chk("beat0_timeout", 1'b0, 1'b1);
  endtask

  task automatic run0(input string tg, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic apx, input logic [16:0] es,
                      input logic [16:0] eco, input logic [31:0] eec, input logic [31:0] eed,
                      output int lat);
    beat0(a, b, cin, apx, lat);
    chk({tg, "_sum"}, s0, es);
    chk({tg, "_co"}, co0, eco);
    @(negedge clk);
    chk({tg, "_ovdrop"}, ov0, 1'b0);
    chk({tg, "_cnt"}, ec0, eec);
    chk({tg, "_dist"}, ed0, eed);
  endtask

  longint mc[3];
  longint md[3];

  task automatic sweep_beat(input int sel, input logic [31:0] a_in, input logic [31:0] b_in,
                            input logic cin, input logic apx);
    logic [63:0] a, b;
    logic [64:0] es, eco, xs, xco, gs, gco;
    longint      mx, d, gc, gd;
    int          w, k, n;
    logic        seen;
    string       tg;
    if (sel == 1) begin
      w = 32; k = 12; mx = 15; tg = "k12";
      a = {32'h0, a_in}; b = {32'h0, b_in};
    end else begin
      w = 16; k = 0; mx = 64'hFFFF_FFFF; tg = "k0";
      a = {48'h0, a_in[15:0]}; b = {48'h0, b_in[15:0]};
    end
    ref_add(w, k, a, b, cin, apx, es, eco);
    ref_add(w, k, a, b, cin, 1'b0, xs, xco);
    @(negedge clk);
    if (sel == 1) begin
      v1 = 1'b1; a1 = a_in; b1 = b_in; cin1 = cin; x1 = apx;
    end else begin
      v2 = 1'b1; a2 = a_in[15:0]; b2 = b_in[15:0]; cin2 = cin; x2 = apx;
    end
    @(negedge clk);
    v1 = 1'b0;
    v2 = 1'b0;
    n = 0;
    seen = (sel == 1) ? ov1 : ov2;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      seen = (sel == 1) ? ov1 : ov2;
    end
    if (!seen) chk({tg, "_timeout"}, 1'b0, 1'b1);
    gs  = (sel == 1) ? 65'(s1) : 65'(s2);
    gco = (sel == 1) ? 65'(co1) : 65'(co2);
    chk({tg, "_sum"}, gs, es);
    chk({tg, "_co"}, gco, eco);
    if (apx) begin
      if (xs != es) mc[sel] = (mc[sel] < mx) ? mc[sel] + 1 : mx;
      d = longint'(xs - es);
      md[sel] = (md[sel] + d > mx) ? mx : md[sel] + d;
    end
    @(negedge clk);
    gc = (sel == 1) ? longint'(ec1) : longint'(ec2);
    gd = (sel == 1) ? longint'(ed1) : longint'(ed2);
    chk({tg, "_cnt"}, gc, mc[sel]);
    chk({tg, "_dist"}, gd, md[sel]);
  endtask

  logic [15:0] sa[6], sb[6];
  logic        sc[6], sx[6];
  logic [16:0] se[6];

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, n, got, cyc;
    logic        saw_nr, stale, held_v;
    logic [16:0] held_s, held_c;

    rst = 1'b1;
    v0 = 0; a0 = '0; b0 = '0; cin0 = 0; x0 = 0; or0 = 1; clr0 = 0;
    v1 = 0; a1 = '0; b1 = '0; cin1 = 0; x1 = 0;
    v2 = 0; a2 = '0; b2 = '0; cin2 = 0; x2 = 0;
    for (int i = 0; i < 3; i++) begin mc[i] = 0; md[i] = 0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ov", ov0, 1'b0);
    chk("rst_ir", ir0, 1'b1);
    chk("rst_sum", s0, 17'h0);
    chk("rst_co", co0, 17'h0);
    chk("rst_cnt", ec0, 32'h0);
    chk("rst_dist", ed0, 32'h0);

    run0("ex_ovf", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 17'h1FFFE, 0, 0, lat);
    chk("latency", lat, 3);
    run0("ap_err", 16'h00FF, 16'h0001, 1'b0, 1'b1, 17'h000FC, 17'h00002, 1, 4, lat);
    run0("ap_bnd", 16'h0080, 16'h0080, 1'b0, 1'b1, 17'h00100, 17'h00100, 1, 4, lat);
    run0("ap_cin", 16'h00FF, 16'h0000, 1'b1, 1'b1, 17'h000FF, 17'h00001, 2, 5, lat);
    run0("ex_keep", 16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h00100, 17'h001FE, 2, 5, lat);

    sa[0] = 16'h1234; sb[0] = 16'h1111; sc[0] = 0; sx[0] = 0; se[0] = 17'h02345;
    sa[1] = 16'hFFFF; sb[1] = 16'hFFFF; sc[1] = 1; sx[1] = 0; se[1] = 17'h1FFFF;
    sa[2] = 16'h00FF; sb[2] = 16'h0001; sc[2] = 0; sx[2] = 1; se[2] = 17'h000FC;
    sa[3] = 16'h8000; sb[3] = 16'h8000; sc[3] = 0; sx[3] = 0; se[3] = 17'h10000;
    sa[4] = 16'h0F0F; sb[4] = 16'h00F1; sc[4] = 0; sx[4] = 1; se[4] = 17'h00FFC;
    sa[5] = 16'h0001; sb[5] = 16'h0002; sc[5] = 1; sx[5] = 0; se[5] = 17'h00004;
    saw_nr = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          v0 = 1'b1; a0 = sa[i]; b0 = sb[i]; cin0 = sc[i]; x0 = sx[i];
          n = 0;
          #2;
          while (!ir0 && n < 60) begin
            saw_nr = 1'b1;
            @(negedge clk);
            #2;
            n++;
          end
          if (!ir0) chk("bp_accept_timeout", 1'b0, 1'b1);
          @(posedge clk);
        end
        @(negedge clk);
        v0 = 1'b0;
      end
      begin
        int m;
        m = 0;
        @(negedge clk);
        while (!ov0 && m < 20) begin
          @(negedge clk);
          m++;
        end
        or0 = 1'b0;
        repeat (5) @(negedge clk);
        or0 = 1'b1;
      end
      begin
        got = 0; cyc = 0; held_v = 1'b0; held_s = '0; held_c = '0;
        while (got < 6 && cyc < 100) begin
          @(negedge clk);
          #3;
          if (ov0 && or0) begin
            chk("bp_sum", s0, se[got]);
            got++;
            held_v = 1'b0;
          end else if (ov0) begin
            if (held_v) begin
              chk("bp_hold_sum", s0, held_s);
              chk("bp_hold_co", co0, held_c);
            end
            held_v = 1'b1; held_s = s0; held_c = co0;
          end
          cyc++;
        end
        if (got < 6) chk("bp_timeout", got, 6);
      end
    join
    @(negedge clk);
    chk("bp_inready_fell", saw_nr, 1'b1);
    chk("bp_cnt", ec0, 32'd4);
    chk("bp_dist", ed0, 32'd13);

    or0 = 1'b1;
    @(negedge clk);
    v0 = 1'b1; a0 = 16'h00FF; b0 = 16'h0001; cin0 = 1'b0; x0 = 1'b1;
    repeat (3) @(negedge clk);
    v0 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_ov", ov0, 1'b0);
    chk("mrst_ir", ir0, 1'b1);
    chk("mrst_cnt", ec0, 32'h0);
    chk("mrst_dist", ed0, 32'h0);
    chk("mrst_sum", s0, 17'h0);
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ov0) stale = 1'b1;
    end
    chk("mrst_stale", stale, 1'b0);

    run0("clr_pre", 16'h00FF, 16'h0001, 1'b0, 1'b1, 17'h000FC, 17'h00002, 1, 4, lat);
    beat0(16'h00FF, 16'h0001, 1'b0, 1'b1, lat);
    chk("clr_sum", s0, 17'h000FC);
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    chk("clr_cnt", ec0, 32'h0);
    chk("clr_dist", ed0, 32'h0);

    for (int i = 0; i < 30; i++)
      sweep_beat(2, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 30; i++)
      sweep_beat(1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 18; i++)
      sweep_beat(1, 32'h0000_0FFF, 32'h0000_0001, 1'b0, 1'b1);
    chk("sat_cnt", ec1, 4'hF);
    chk("sat_dist", ed1, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
